// File: rtl/compress_handler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : compress_handler_pkg
// Purpose  : Shared definitions for the run-length compressor.
//            - Token field positions: value in bit 7, run length in bits 6:0.
//            - The longest run one token can carry and the padding token.
//            - FSM state encodings for compress_handler.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package compress_handler_pkg;

   // Token layout
   localparam int TOK_VAL_BIT = 7;
   localparam int TOK_LEN_MSB = 6;
   localparam int TOK_LEN_LSB = 0;

   // Longest run a single token can describe
   localparam logic [6:0] MAX_RUN = 7'd127;

   // The decoder skips this token; it fills the lower half of a final, unpaired token
   localparam logic [7:0] PAD_TOKEN = 8'h00;

   // Compressor FSM states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_SCAN  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   // Build a token from a run value and run length
   function automatic logic [7:0] make_token(input logic run_bit, input logic [6:0] run_len);
      logic [7:0] tok;
      tok                          = PAD_TOKEN;
      tok[TOK_VAL_BIT]             = run_bit;
      tok[TOK_LEN_MSB:TOK_LEN_LSB] = run_len;
      return tok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/compress_handler_token_packer.sv
`default_nettype none
// ============================================================================
// Module   : token_packer
// Purpose  : Pairs 8-bit run-length tokens into 16-bit output words. The first
//            token of a pair lands in the upper byte, the second in the lower
//            byte. A flush request completes a half-filled pair with the padding
//            token. Owns the Dout/doutValid register and tells the producer
//            when it must stall.
// Ports    :
//   clk            in   system clock
//   RST            in   synchronous active-high reset
//   tok_valid_i    in   producer offers tok_i this cycle
//   tok_i    [7:0] in   token offered
//   flush_i        in   tok_i is the last token; pad the pair if needed
//   stall_o        out  offered token is not taken this cycle
//   empty_o        out  no half pair held and no word pending
//   dout_o  [15:0] out  packed token pair
//   dout_valid_o   out  dout_o holds a valid word
//   dout_ready_i   in   consumer takes dout_o
// Revision : 1.0 - initial release
// ============================================================================
module token_packer
   import compress_handler_pkg::*;
(
   input  logic        clk,
   input  logic        RST,
   input  logic        tok_valid_i,
   input  logic [7:0]  tok_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        empty_o,
   output logic [15:0] dout_o,
   output logic        dout_valid_o,
   input  logic        dout_ready_i
);

   logic [7:0]  hi_q,    hi_d;      // first token of the pair being built
   logic        half_q,  half_d;    // hi_q holds a token
   logic [15:0] dout_q,  dout_d;
   logic        valid_q, valid_d;
   logic        accept;

   // A pending word that is not leaving this cycle blocks any new token.
   // The word register frees up in the same cycle it transfers, so a new
   // word can load back-to-back without a bubble.
   assign stall_o = valid_q & ~dout_ready_i;
   assign accept  = tok_valid_i & ~stall_o;
   assign empty_o = ~valid_q & ~half_q;

   always_comb begin
      hi_d    = hi_q;
      half_d  = half_q;
      dout_d  = dout_q;
      valid_d = valid_q;

      if (valid_q && dout_ready_i) begin
         valid_d = 1'b0;
      end

      if (accept) begin
         if (half_q) begin
            dout_d  = {hi_q, tok_i};
            valid_d = 1'b1;
            half_d  = 1'b0;
         end else if (flush_i) begin
            dout_d  = {tok_i, PAD_TOKEN};
            valid_d = 1'b1;
         end else begin
            hi_d    = tok_i;
            half_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         hi_q    <= PAD_TOKEN;
         half_q  <= 1'b0;
         dout_q  <= 16'h0000;
         valid_q <= 1'b0;
      end else begin
         hi_q    <= hi_d;
         half_q  <= half_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/compress_handler.sv
`default_nettype none
// ============================================================================
// Module   : compress_handler
// Purpose  : Run-length bit-stream compressor. Reads byteCount bytes from RAM
//            starting at startAddress, walks the bits MSB first and emits
//            {bit, run length} tokens, packed two per 16-bit output word.
// Ports    :
//   clk                   in   system clock
//   RST                   in   synchronous active-high reset, aborts any job
//   start                 in   begin a job (sampled only when idle)
//   startAddress [A-1:0]  in   first RAM byte address
//   byteCount    [C-1:0]  in   bytes to compress
//   ramAddress   [A-1:0]  out  RAM read address
//   ramReadSignal         out  read request, held until ramDoneRead
//   ramDoneRead           in   read complete, ramDataIn valid
//   ramDataIn    [7:0]    in   byte from RAM
//   Dout         [15:0]   out  packed token pair
//   doutValid             out  Dout valid
//   doutReady             in   consumer takes Dout
//   busy                  out  job in progress
//   done                  out  one-cycle pulse once the last word is taken
// Revision : 1.0 - initial release
// ============================================================================
module compress_handler
   import compress_handler_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] startAddress,
   input  logic [CNT_W-1:0]  byteCount,
   output logic [ADDR_W-1:0] ramAddress,
   output logic              ramReadSignal,
   input  logic              ramDoneRead,
   input  logic [7:0]        ramDataIn,
   output logic [15:0]       Dout,
   output logic              doutValid,
   input  logic              doutReady,
   output logic              busy,
   output logic              done
);

   state_e              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                rd_q;
   logic                busy_q;
   logic                done_q;
   logic [CNT_W-1:0]    left_q;     // bytes still to scan, including the current one
   logic [7:0]          shift_q;    // current byte, next bit in [7]
   logic [2:0]          bitcnt_q;   // bits already consumed from the current byte
   logic                run_bit_q;
   logic [6:0]          run_len_q;
   logic                first_q;    // no bit of the stream consumed yet

   logic                cur_bit;
   logic                emit_scan;
   logic                tok_valid;
   logic                flush;
   logic [7:0]          tok;
   logic                stall;
   logic                packer_empty;
   logic                hold;

   assign cur_bit = shift_q[7];

   // A run ends when the bit changes or it has reached the longest length a
   // token can carry; the very first bit only opens a run.
   assign emit_scan = (state_q == ST_SCAN) && !first_q &&
                      ((cur_bit != run_bit_q) || (run_len_q == MAX_RUN));
   assign flush     = (state_q == ST_FLUSH);
   assign tok_valid = emit_scan || flush;
   assign tok       = make_token(run_bit_q, run_len_q);

   // Nothing advances while a token is offered but cannot be taken
   assign hold      = tok_valid && stall;

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         left_q    <= '0;
         shift_q   <= 8'h00;
         bitcnt_q  <= 3'd0;
         run_bit_q <= 1'b0;
         run_len_q <= 7'd0;
         first_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (byteCount == '0) begin
                     // Empty job: finish immediately without touching RAM
                     done_q <= 1'b1;
                  end else begin
                     addr_q  <= startAddress;
                     left_q  <= byteCount;
                     busy_q  <= 1'b1;
                     rd_q    <= 1'b1;
                     first_q <= 1'b1;
                     state_q <= ST_REQ;
                  end
               end
            end

            ST_REQ: begin
               if (ramDoneRead) begin
                  shift_q  <= ramDataIn;
                  rd_q     <= 1'b0;
                  bitcnt_q <= 3'd0;
                  state_q  <= ST_SCAN;
               end
            end

            ST_SCAN: begin
               if (!hold) begin
                  shift_q  <= {shift_q[6:0], 1'b0};
                  bitcnt_q <= bitcnt_q + 3'd1;

                  if (first_q || emit_scan) begin
                     run_bit_q <= cur_bit;
                     run_len_q <= 7'd1;
                     first_q   <= 1'b0;
                  end else begin
                     run_len_q <= run_len_q + 7'd1;
                  end

                  // Last bit of this byte; the run itself carries over
                  if (bitcnt_q == 3'd7) begin
                     if (left_q != CNT_W'(1)) begin
                        left_q  <= left_q - CNT_W'(1);
                        addr_q  <= addr_q + ADDR_W'(1);
                        rd_q    <= 1'b1;
                        state_q <= ST_REQ;
                     end else begin
                        state_q <= ST_FLUSH;
                     end
                  end
               end
            end

            ST_FLUSH: begin
               if (!stall) begin
                  state_q <= ST_DRAIN;
               end
            end

            ST_DRAIN: begin
               if (packer_empty) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   token_packer u_packer (
      .clk          (clk),
      .RST          (RST),
      .tok_valid_i  (tok_valid),
      .tok_i        (tok),
      .flush_i      (flush),
      .stall_o      (stall),
      .empty_o      (packer_empty),
      .dout_o       (Dout),
      .dout_valid_o (doutValid),
      .dout_ready_i (doutReady)
   );

   assign ramAddress    = addr_q;
   assign ramReadSignal = rd_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_compress_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_compress_handler
// Purpose  : Self-checking bench for compress_handler. Jobs are described by a
//            RAM image; a reference model turns each image into the expected
//            word sequence, and a monitor compares every transferred word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_compress_handler;

   logic        clk = 1'b0;
   logic        RST;
   logic        start;
   logic [15:0] startAddress;
   logic [15:0] byteCount;
   logic [15:0] ramAddress;
   logic        ramReadSignal;
   logic        ramDoneRead;
   logic [7:0]  ramDataIn;
   logic [15:0] Dout;
   logic        doutValid;
   logic        doutReady;
   logic        busy;
   logic        done;

   logic [7:0]  mem [0:65535];
   logic [15:0] exp_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int read_count = 0;
   int done_count = 0;
   int words_seen = 0;
   int stall_cnt  = 0;
   int ready_mode = 0;
   bit valid_seen = 0;

   compress_handler #(.ADDR_W(16), .CNT_W(16)) dut (
      .clk           (clk),
      .RST           (RST),
      .start         (start),
      .startAddress  (startAddress),
      .byteCount     (byteCount),
      .ramAddress    (ramAddress),
      .ramReadSignal (ramReadSignal),
      .ramDoneRead   (ramDoneRead),
      .ramDataIn     (ramDataIn),
      .Dout          (Dout),
      .doutValid     (doutValid),
      .doutReady     (doutReady),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Reference: walk the bit stream, cut runs at a bit change or at 127,
   // pair tokens and pad an odd final token with 8'h00.
   task automatic model_push(input logic [15:0] addr, input int cnt);
      logic [7:0] toks[$];
      logic [7:0] b;
      logic       rb;
      int         rl;
      rb = 1'b0;
      rl = 0;
      for (int i = 0; i < cnt; i++) begin
         b = mem[16'(addr + 16'(i))];
         for (int k = 7; k >= 0; k--) begin
            if (rl == 0) begin
               rb = b[k];
               rl = 1;
            end else if (b[k] == rb && rl < 127) begin
               rl++;
            end else begin
               toks.push_back({rb, 7'(rl)});
               rb = b[k];
               rl = 1;
            end
         end
      end
      if (rl > 0) toks.push_back({rb, 7'(rl)});
      if (toks.size() % 2 == 1) toks.push_back(8'h00);
      for (int j = 0; j < toks.size(); j += 2) exp_q.push_back({toks[j], toks[j+1]});
   endtask

   // RAM/DMA responder: answers a held request after 0..2 idle cycles
   initial begin
      int wait_cnt;
      wait_cnt    = 0;
      ramDoneRead = 1'b0;
      ramDataIn   = 8'h00;
      forever begin
         @(negedge clk);
         if (ramDoneRead) begin
            ramDoneRead = 1'b0;
         end else if (ramReadSignal) begin
            if (wait_cnt == 0) begin
               ramDoneRead = 1'b1;
               ramDataIn   = mem[ramAddress];
               read_count++;
               wait_cnt    = $urandom_range(0, 2);
            end else begin
               wait_cnt--;
            end
         end
      end
   end

   // Consumer ready: 0 = always ready, 1 = random, 2 = stall 10 cycles after first word
   initial begin
      doutReady = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: doutReady = 1'b1;
            1: doutReady = ($urandom_range(0, 3) != 0);
            default: begin
               if (words_seen == 1 && stall_cnt < 10) begin
                  doutReady = 1'b0;
                  stall_cnt++;
               end else begin
                  doutReady = 1'b1;
               end
            end
         endcase
      end
   end

   // Monitor: words transfer at the next rising edge when valid && ready here
   initial begin
      logic [15:0] held;
      logic [15:0] e;
      bit          hold_valid;
      hold_valid = 0;
      held       = 16'h0;
      forever begin
         @(negedge clk);
         if (RST) begin
            hold_valid = 0;
         end else begin
            if (hold_valid) check("dout_hold", {15'h0, doutValid, Dout}, {15'h0, 1'b1, held});
            hold_valid = doutValid && !doutReady;
            held       = Dout;
            if (doutValid) valid_seen = 1;
            if (doutValid && doutReady) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_word: got %0h required none", Dout);
               end else begin
                  e = exp_q.pop_front();
                  check("word", {16'h0, Dout}, {16'h0, e});
               end
               words_seen++;
            end
            if (done) done_count++;
         end
      end
   end

   task automatic run_job(input logic [15:0] addr, input int cnt, input int mode, input bit restart);
      int cyc;
      model_push(addr, cnt);
      ready_mode = mode;
      read_count = 0;
      done_count = 0;
      stall_cnt  = 0;
      words_seen = 0;
      valid_seen = 0;
      @(posedge clk); #1;
      start        = 1'b1;
      startAddress = addr;
      byteCount    = 16'(cnt);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", {31'h0, busy}, (cnt != 0) ? 32'd1 : 32'd0);
      if (cnt == 0) check("zero_done_next", {31'h0, done}, 32'd1);
      if (restart) begin
         repeat (4) @(posedge clk);
         #1;
         start        = 1'b1;
         startAddress = addr + 16'd100;
         byteCount    = 16'd3;
         @(posedge clk); #1;
         start = 1'b0;
      end
      cyc = 0;
      while (!done && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("done_timeout", (cyc < 20000) ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk); #1;
      check("done_one_cycle", {31'h0, done}, 32'd0);
      check("busy_cleared", {31'h0, busy}, 32'd0);
      check("words_left", exp_q.size(), 32'd0);
      check("ram_reads", read_count, cnt);
      check("done_pulses", done_count, 32'd1);
      if (cnt == 0) check("zero_no_valid", {31'h0, valid_seen}, 32'd0);
      exp_q.delete();
   endtask

   task automatic check_reset_values();
      check("rst_ramAddress", {16'h0, ramAddress}, 32'd0);
      check("rst_ramRead", {31'h0, ramReadSignal}, 32'd0);
      check("rst_Dout", {16'h0, Dout}, 32'd0);
      check("rst_doutValid", {31'h0, doutValid}, 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
   endtask

   initial begin
      int cyc;
      logic [15:0] a;
      int n;
      RST          = 1'b1;
      start        = 1'b0;
      startAddress = 16'h0;
      byteCount    = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      @(posedge clk); #1;
      RST = 1'b0;

      // Single byte F0 -> 8404
      mem[16'h0010] = 8'hF0;
      run_job(16'h0010, 1, 0, 0);

      // Single byte 00 -> 0800
      mem[16'h0020] = 8'h00;
      run_job(16'h0020, 1, 0, 0);

      // 128 ones -> FF81, with an ignored second start
      for (int i = 0; i < 16; i++) mem[16'h0100 + 16'(i)] = 8'hFF;
      run_job(16'h0100, 16, 0, 1);

      // AA -> four 8101 words, consumer stalls after the first
      mem[16'h0030] = 8'hAA;
      run_job(16'h0030, 1, 2, 0);

      // Empty job
      run_job(16'h0040, 0, 0, 0);

      // Abort during SCAN of a 4-byte job
      for (int i = 0; i < 4; i++) mem[16'h0200 + 16'(i)] = 8'($urandom);
      ready_mode = 0;
      done_count = 0;
      @(posedge clk); #1;
      start        = 1'b1;
      startAddress = 16'h0200;
      byteCount    = 16'd4;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!ramDoneRead && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("abort_read_timeout", (cyc < 100) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      RST = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_values();
      exp_q.delete();
      done_count = 0;
      @(posedge clk); #1;
      RST = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", done_count, 32'd0);
      run_job(16'h0200, 4, 1, 0);

      // Random jobs, one straddling the address wrap
      for (int j = 0; j < 6; j++) begin
         a = (j == 0) ? 16'hFFFC : 16'(16'h1000 + 16'($urandom_range(0, 4000)));
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
               0:       mem[16'(a + 16'(i))] = 8'h00;
               1:       mem[16'(a + 16'(i))] = 8'hFF;
               default: mem[16'(a + 16'(i))] = 8'($urandom);
            endcase
         end
         run_job(a, n, 1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
